// File: rtl/lighthouse_sweep_collector.sv
// Collects one-cycle sweep records from many sensor channels into a single FIFO stream.
// Each channel holds one pending record; a round-robin arbiter moves one record per cycle into the FIFO.
module lighthouse_sweep_collector #(
    parameter int NUMBER_OF_SENSORS = 20,
    parameter int DATA_WIDTH        = 32,
    parameter int FIFO_DEPTH        = 16,
    localparam int ID_WIDTH         = 5
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUMBER_OF_SENSORS-1:0]            sensor_valid_i,
    input  logic [NUMBER_OF_SENSORS*DATA_WIDTH-1:0] sensor_data_i,
    input  logic [NUMBER_OF_SENSORS-1:0]            enable_mask_i,
    input  logic                                    clear_i,
    output logic                                    out_valid_o,
    input  logic                                    out_ready_i,
    output logic [ID_WIDTH+DATA_WIDTH-1:0]          out_data_o,
    output logic [$clog2(FIFO_DEPTH):0]             fifo_level_o,
    output logic [NUMBER_OF_SENSORS-1:0]            drop_flags_o,
    output logic [15:0]                             drop_count_o
);

    localparam int N  = NUMBER_OF_SENSORS;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = ID_WIDTH + DATA_WIDTH;

    // Per-channel pending state
    logic                  pending_valid_reg [N];
    logic [DATA_WIDTH-1:0] pending_data_reg  [N];
    logic [N-1:0]          eligible;
    logic [N-1:0]          drop_vec;

    // Arbiter state
    logic [ID_WIDTH-1:0] rr_ptr_reg;
    logic [ID_WIDTH-1:0] rr_ptr_next;
    logic                grant_found;
    logic [ID_WIDTH-1:0] grant_idx;
    logic [ID_WIDTH:0]   scan_sum;
    logic [ID_WIDTH-1:0] scan_idx;

    // FIFO state
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic          pop;
    logic          push;
    logic          push_allowed;

    // Drop statistics
    logic [N-1:0]  drop_flags_reg;
    logic [N-1:0]  drop_flags_next;
    logic [15:0]   drop_count_reg;
    logic [15:0]   drop_count_next;
    logic [ID_WIDTH:0] drop_total;
    logic [16:0]   drop_sum;

    assign pop          = out_valid_o && out_ready_i;
    assign push_allowed = (level_reg < LW'(FIFO_DEPTH)) || pop;
    assign push         = grant_found;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            logic strobe;
            logic granted;

            assign strobe       = sensor_valid_i[gi] && enable_mask_i[gi];
            assign granted      = grant_found && (grant_idx == ID_WIDTH'(gi));
            assign eligible[gi] = pending_valid_reg[gi] && enable_mask_i[gi];
            // A strobe onto the channel being granted this cycle is not a loss:
            // the old record leaves through the FIFO as the new one lands.
            assign drop_vec[gi] = strobe && pending_valid_reg[gi] && !granted;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pending_valid_reg[gi] <= 1'b0;
                end else if (strobe) begin
                    pending_valid_reg[gi] <= 1'b1;
                end else if (granted || !enable_mask_i[gi]) begin
                    pending_valid_reg[gi] <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (strobe) begin
                    pending_data_reg[gi] <= sensor_data_i[DATA_WIDTH*gi +: DATA_WIDTH];
                end
            end
        end
    endgenerate

    // Search starts at rr_ptr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        if (push_allowed) begin
            for (int k = 0; k < N; k++) begin
                scan_sum = {1'b0, rr_ptr_reg} + (ID_WIDTH+1)'(k);
                if (scan_sum >= (ID_WIDTH+1)'(N)) begin
                    scan_sum = scan_sum - (ID_WIDTH+1)'(N);
                end
                scan_idx = scan_sum[ID_WIDTH-1:0];
                if (!grant_found && eligible[scan_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_found) begin
            rr_ptr_next = (grant_idx == ID_WIDTH'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {grant_idx, pending_data_reg[grant_idx]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                level_reg <= level_reg + 1'b1;
            end else if (pop && !push) begin
                level_reg <= level_reg - 1'b1;
            end
        end
    end

    assign out_valid_o  = (level_reg != '0);
    assign out_data_o   = out_valid_o ? fifo_mem[rd_ptr_reg] : '0;
    assign fifo_level_o = level_reg;

    // Clear restarts the statistics from this cycle's drops, so a coincident drop survives.
    always_comb begin
        drop_total = '0;
        for (int k = 0; k < N; k++) begin
            drop_total = drop_total + (ID_WIDTH+1)'(drop_vec[k]);
        end
        drop_sum        = (clear_i ? 17'd0 : {1'b0, drop_count_reg}) + 17'(drop_total);
        drop_count_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        drop_flags_next = (clear_i ? '0 : drop_flags_reg) | drop_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_flags_reg <= '0;
            drop_count_reg <= '0;
        end else begin
            drop_flags_reg <= drop_flags_next;
            drop_count_reg <= drop_count_next;
        end
    end

    assign drop_flags_o = drop_flags_reg;
    assign drop_count_o = drop_count_reg;

endmodule

// File: doc/lighthouse_sweep_collector.md
LIGHTHOUSE_SWEEP_COLLECTOR -- requirements
Module: lighthouse_sweep_collector

Interface
REQ-001 SHALL have parameter NUMBER_OF_SENSORS, default 20, number of sensor channels (1..32).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of one per-sensor sweep record.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, output FIFO entries (power of two, >=2).
REQ-004 SHALL have localparam ID_WIDTH = 5, sensor-index field width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have sensor_valid_i  input  NUMBER_OF_SENSORS  one-cycle record strobe per channel.
REQ-007 SHALL have sensor_data_i  input  NUMBER_OF_SENSORS*DATA_WIDTH  channel i at bits [DATA_WIDTH*(i+1)-1:DATA_WIDTH*i].
REQ-008 SHALL have enable_mask_i  input  NUMBER_OF_SENSORS  1 = channel participates.
REQ-009 SHALL have clear_i  input  1  synchronous clear of statistics.
REQ-010 SHALL have out_valid_o  output  1  FIFO head valid.
REQ-011 SHALL have out_ready_i  input  1  consumer accepts head.
REQ-012 SHALL have out_data_o  output  ID_WIDTH+DATA_WIDTH  {sensor index, record}.
REQ-013 SHALL have fifo_level_o  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have drop_flags_o  output  NUMBER_OF_SENSORS  sticky per-channel overwrite flag.
REQ-015 SHALL have drop_count_o  output  16  saturating total overwrite count.

Function
REQ-016 Each channel SHALL own a one-deep pending register (flag + data); sensor_valid_i[i] with enable_mask_i[i]=1 SHALL load it at that clock edge.
REQ-017 sensor_valid_i[i] with enable_mask_i[i]=0 SHALL be ignored; a pending entry whose mask is 0 SHALL be cleared and never granted.
REQ-018 Round-robin arbiter: each cycle with FIFO push allowed, grant the first pending enabled channel at index >= rr_ptr, wrapping to 0; push {i, data}; clear that pending flag; rr_ptr <= (grant+1) mod NUMBER_OF_SENSORS.
REQ-019 No grant SHALL leave rr_ptr unchanged; at most one push per cycle.
REQ-020 Push allowed when fifo_level_o < FIFO_DEPTH, or when FIFO full and a pop (out_valid_o && out_ready_i) occurs the same cycle.
REQ-021 New strobe on a channel still pending and not granted that cycle: data overwritten, drop_flags_o[i] set, drop_count_o += 1 (saturates at 65535); multiple simultaneous drops SHALL add their count in one cycle, saturating.
REQ-022 New strobe on the channel granted that same cycle: old data pushed, new data becomes pending, no drop.
REQ-023 Latency: strobe sampled at edge k with empty FIFO and no contention -> out_valid_o high and out_data_o valid after edge k+1.
REQ-024 out_valid_o = (fifo_level_o != 0); out_data_o SHALL hold stable while out_valid_o && !out_ready_i.
REQ-025 Pop on out_valid_o && out_ready_i; out_ready_i with FIFO empty SHALL have no effect; level SHALL never exceed FIFO_DEPTH nor underflow.
REQ-026 Simultaneous push and pop SHALL leave fifo_level_o unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-027 clear_i SHALL zero drop_flags_o and drop_count_o at the next edge; a drop in the same cycle as clear_i SHALL win (flag set, count = 1); FIFO and pending state unaffected.

Reset
REQ-028 rst SHALL asynchronously clear all pending flags, rr_ptr=0, FIFO pointers, fifo_level_o=0, out_valid_o=0, out_data_o=0, drop_flags_o=0, drop_count_o=0.
REQ-029 rst asserted mid-operation SHALL discard all buffered records; first strobe after release SHALL behave as REQ-023.

Verification
REQ-030 Single strobe ch3, data 0xDEADBEEF, ready=1 -> one cycle later out_valid_o=1, out_data_o={5'd3,0xDEADBEEF}, then empty.
REQ-031 Strobes ch0, ch5, ch19 same cycle, rr_ptr=0, ready=1 -> output order 0, 5, 19 on consecutive cycles; next simultaneous 0 and 19 -> order 0, 19.
REQ-032 ready=0, FIFO_DEPTH=16, 20 strobes -> level 16, 4 pending remain; one more strobe on a pending channel -> drop_count_o=1, its drop flag set.
REQ-033 FIFO full, ready=1 continuously with pending entries -> level stays 16, one record out per cycle, no drops.
REQ-034 enable_mask_i[7]=0, strobe ch7 -> nothing output, no drop; clear_i after REQ-032 -> drop_count_o=0, flags 0.
REQ-035 rst pulse with 10 entries queued -> out_valid_o=0 and level 0 immediately, without a clock edge.
